// File: rtl/psum_buf_arbiter_if.sv
// ---------------------------------------------------------------------------
// psum_buf_arbiter_if
//
// Bundles every handshake and scratchpad signal of the partial-sum buffer
// arbiter so the arbiter can be wired with a single port.
//
//   Requester side   : clear/clear_done, wr_*, acc_*, rd_*, acc_ovf, busy
//   Scratchpad side  : mem_en, mem_we, mem_addr, mem_wdata, mem_rdata
//
// Modports
//   slave  : the arbiter itself (takes requests, drives grants and the macro)
//   master : the surroundings, i.e. controller/PE datapath plus the psum
//            scratchpad macro (drives requests and mem_rdata)
// ---------------------------------------------------------------------------
interface psum_buf_arbiter_if #(
    parameter int ADDR_LEN   = 4,
    parameter int DATA_WIDTH = 16
);
    // sequenced clear
    logic                  clear;
    logic                  clear_done;

    // PE write-back
    logic                  wr_req;
    logic [ADDR_LEN-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_gnt;

    // JUST_ADD accumulate (read-modify-write)
    logic                  acc_req;
    logic [ADDR_LEN-1:0]   acc_addr;
    logic [DATA_WIDTH-1:0] acc_data;
    logic                  acc_gnt;

    // output drain read
    logic                  rd_req;
    logic [ADDR_LEN-1:0]   rd_addr;
    logic                  rd_gnt;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;

    // status
    logic                  acc_ovf;
    logic                  busy;

    // single-port scratchpad macro
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_LEN-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  clear,
        output clear_done,
        input  wr_req, wr_addr, wr_data,
        output wr_gnt,
        input  acc_req, acc_addr, acc_data,
        output acc_gnt,
        input  rd_req, rd_addr,
        output rd_gnt, rd_data, rd_valid,
        output acc_ovf, busy,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output clear,
        input  clear_done,
        output wr_req, wr_addr, wr_data,
        input  wr_gnt,
        output acc_req, acc_addr, acc_data,
        input  acc_gnt,
        output rd_req, rd_addr,
        input  rd_gnt, rd_data, rd_valid,
        input  acc_ovf, busy,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/psum_buf_arbiter.sv
// ---------------------------------------------------------------------------
// psum_buf_arbiter
//
// Shares the single-port partial-sum scratchpad between three requesters:
// PE write-back (wr), JUST_ADD accumulate read-modify-write (acc) and the
// output drain (rd), and adds a sequenced clear that zeroes the buffer.
//
// Ports
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous, active-high reset
//   bus  : psum_buf_arbiter_if.slave
//            requester handshakes (req/addr/data in, combinational gnt out),
//            rd_data/rd_valid, acc_ovf (sticky), busy, clear/clear_done and
//            the scratchpad macro pins mem_en/mem_we/mem_addr/mem_wdata
//            (out) and mem_rdata (in, valid the cycle after a read).
//
// Timing summary
//   wr  : 1 cycle, written on the granting edge
//   rd  : read issued on grant, rd_valid/rd_data the following cycle
//   acc : read on grant, write-back of (old + addend) in ACC_WB, 2 cycles
//   clr : DEPTH zero writes, clear_done pulses the cycle after the last one
// ---------------------------------------------------------------------------
module psum_buf_arbiter #(
    parameter int ADDR_LEN   = 4,
    parameter int DEPTH      = 16,  // must not exceed 2**ADDR_LEN
    parameter int DATA_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    psum_buf_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_ACC_WB = 2'd1,
        ST_CLEAR  = 2'd2
    } state_t;

    // Requester identities; the numeric value is also the bit position in
    // req_vec/gnt_vec.
    typedef enum logic [1:0] {
        SRC_WR  = 2'd0,
        SRC_ACC = 2'd1,
        SRC_RD  = 2'd2
    } src_t;

    localparam logic [ADDR_LEN-1:0] LAST_ADDR = ADDR_LEN'(DEPTH - 1);
    localparam int                  MSB       = DATA_WIDTH - 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                state_reg,      state_next;
    src_t                  rr_last_reg,    rr_last_next;
    logic                  clear_pend_reg, clear_pend_next;
    logic [ADDR_LEN-1:0]   clr_cnt_reg,    clr_cnt_next;
    logic [ADDR_LEN-1:0]   acc_addr_reg,   acc_addr_next;
    logic [DATA_WIDTH-1:0] acc_data_reg,   acc_data_next;
    logic                  acc_ovf_reg,    acc_ovf_next;
    logic                  rd_valid_reg,   rd_valid_next;
    logic                  clear_done_reg, clear_done_next;
    logic [DATA_WIDTH-1:0] rd_data_reg;

    // ------------------------------------------------------------------
    // Round-robin winner selection
    // ------------------------------------------------------------------
    logic [2:0] req_vec;
    logic [2:0] gnt_vec;
    logic       any_req;
    logic       grant_valid;
    src_t       first_src;
    src_t       second_src;
    src_t       win_src;

    // Next requester in the fixed cycle wr -> acc -> rd -> wr.
    function automatic src_t succ(input src_t s);
        case (s)
            SRC_WR:  return SRC_ACC;
            SRC_ACC: return SRC_RD;
            default: return SRC_WR;
        endcase
    endfunction

    assign req_vec = {bus.rd_req, bus.acc_req, bus.wr_req};
    assign any_req = |req_vec;

    // Search starts just after the last winner; the last winner itself is
    // checked last, so it only wins again when nobody else is asking.
    always_comb begin
        first_src  = succ(rr_last_reg);
        second_src = succ(first_src);
        win_src    = rr_last_reg;
        if (req_vec[first_src]) begin
            win_src = first_src;
        end else if (req_vec[second_src]) begin
            win_src = second_src;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_gnt
            assign gnt_vec[gi] = grant_valid && (2'(win_src) == 2'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Accumulate write-back arithmetic (wraps mod 2**DATA_WIDTH)
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] wb_sum;
    logic                  wb_ovf;

    assign wb_sum = bus.mem_rdata + acc_data_reg;
    // Signed overflow: both operands share a sign the result does not.
    assign wb_ovf = (bus.mem_rdata[MSB] == acc_data_reg[MSB]) &&
                    (wb_sum[MSB] != bus.mem_rdata[MSB]);

    // ------------------------------------------------------------------
    // FSM next-state / scratchpad command
    // ------------------------------------------------------------------
    logic                  mem_en_comb;
    logic                  mem_we_comb;
    logic [ADDR_LEN-1:0]   mem_addr_comb;
    logic [DATA_WIDTH-1:0] mem_wdata_comb;

    always_comb begin
        state_next      = state_reg;
        rr_last_next    = rr_last_reg;
        clear_pend_next = clear_pend_reg;
        clr_cnt_next    = clr_cnt_reg;
        acc_addr_next   = acc_addr_reg;
        acc_data_next   = acc_data_reg;
        acc_ovf_next    = acc_ovf_reg;
        rd_valid_next   = 1'b0;
        clear_done_next = 1'b0;
        grant_valid     = 1'b0;
        mem_en_comb     = 1'b0;
        mem_we_comb     = 1'b0;
        mem_addr_comb   = '0;
        mem_wdata_comb  = '0;

        case (state_reg)
            ST_ARB: begin
                if (clear_pend_reg || bus.clear) begin
                    // Clear beats every requester; this cycle is spent
                    // switching over, so nobody is granted.
                    state_next      = ST_CLEAR;
                    clear_pend_next = 1'b0;
                    clr_cnt_next    = '0;
                    acc_ovf_next    = 1'b0;
                end else if (any_req) begin
                    grant_valid  = 1'b1;
                    rr_last_next = win_src;
                    case (win_src)
                        SRC_WR: begin
                            mem_en_comb    = 1'b1;
                            mem_we_comb    = 1'b1;
                            mem_addr_comb  = bus.wr_addr;
                            mem_wdata_comb = bus.wr_data;
                        end
                        SRC_ACC: begin
                            // Read now, write the sum back next cycle.
                            mem_en_comb   = 1'b1;
                            mem_addr_comb = bus.acc_addr;
                            acc_addr_next = bus.acc_addr;
                            acc_data_next = bus.acc_data;
                            state_next    = ST_ACC_WB;
                        end
                        default: begin
                            mem_en_comb   = 1'b1;
                            mem_addr_comb = bus.rd_addr;
                            rd_valid_next = 1'b1;
                        end
                    endcase
                end
            end

            ST_ACC_WB: begin
                mem_en_comb    = 1'b1;
                mem_we_comb    = 1'b1;
                mem_addr_comb  = acc_addr_reg;
                mem_wdata_comb = wb_sum;
                if (wb_ovf) begin
                    acc_ovf_next = 1'b1;
                end
                // A clear arriving mid-RMW waits until the write-back lands.
                if (bus.clear) begin
                    clear_pend_next = 1'b1;
                end
                state_next = ST_ARB;
            end

            ST_CLEAR: begin
                // Clear pulses here are deliberately dropped: the sweep in
                // progress already zeroes everything.
                mem_en_comb   = 1'b1;
                mem_we_comb   = 1'b1;
                mem_addr_comb = clr_cnt_reg;
                if (clr_cnt_reg == LAST_ADDR) begin
                    clr_cnt_next    = '0;
                    clear_done_next = 1'b1;
                    state_next      = ST_ARB;
                end else begin
                    clr_cnt_next = clr_cnt_reg + ADDR_LEN'(1);
                end
            end

            default: begin
                state_next = ST_ARB;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_ARB;
            rr_last_reg    <= SRC_RD;   // wr is first in line after reset
            clear_pend_reg <= 1'b0;
            clr_cnt_reg    <= '0;
            acc_addr_reg   <= '0;
            acc_data_reg   <= '0;
            acc_ovf_reg    <= 1'b0;
            rd_valid_reg   <= 1'b0;
            clear_done_reg <= 1'b0;
            rd_data_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            rr_last_reg    <= rr_last_next;
            clear_pend_reg <= clear_pend_next;
            clr_cnt_reg    <= clr_cnt_next;
            acc_addr_reg   <= acc_addr_next;
            acc_data_reg   <= acc_data_next;
            acc_ovf_reg    <= acc_ovf_next;
            rd_valid_reg   <= rd_valid_next;
            clear_done_reg <= clear_done_next;
            // Keep the last drained value on rd_data between reads.
            if (rd_valid_reg) begin
                rd_data_reg <= bus.mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Combinational outputs are forced low while rst is held so a reset
    // mid-RMW/mid-clear silences the macro and grants immediately.
    assign bus.wr_gnt    = !rst && gnt_vec[SRC_WR];
    assign bus.acc_gnt   = !rst && gnt_vec[SRC_ACC];
    assign bus.rd_gnt    = !rst && gnt_vec[SRC_RD];

    assign bus.mem_en    = !rst && mem_en_comb;
    assign bus.mem_we    = !rst && mem_we_comb;
    assign bus.mem_addr  = rst ? '0 : mem_addr_comb;
    assign bus.mem_wdata = rst ? '0 : mem_wdata_comb;

    // The macro returns data one cycle after the read, which is exactly the
    // rd_valid cycle, so pass it straight through then and hold otherwise.
    assign bus.rd_valid   = rd_valid_reg;
    assign bus.rd_data    = rd_valid_reg ? bus.mem_rdata : rd_data_reg;
    assign bus.acc_ovf    = acc_ovf_reg;
    assign bus.clear_done = clear_done_reg;
    assign bus.busy       = (state_reg != ST_ARB);

endmodule

// File: tb/tb_psum_buf_arbiter.sv
// ---------------------------------------------------------------------------
// tb_psum_buf_arbiter
//
// Self-checking bench: a scratchpad model answers the arbiter's memory
// commands, and a behavioural model of the buffer (contents array, priority
// index, remaining-work counters) predicts every output on every cycle.
// Directed sequences pin the model with hand-computed literals, then a
// randomized phase runs against the model.
// ---------------------------------------------------------------------------
module tb_psum_buf_arbiter;
    localparam int ADDR_LEN   = 4;
    localparam int DEPTH      = 16;
    localparam int DATA_WIDTH = 16;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    psum_buf_arbiter_if #(.ADDR_LEN(ADDR_LEN), .DATA_WIDTH(DATA_WIDTH)) bus ();

    psum_buf_arbiter #(
        .ADDR_LEN(ADDR_LEN), .DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- scratchpad macro: sync read, 1-cycle latency -------
    logic [15:0] spad [DEPTH] = '{default: 16'h0000};
    logic [15:0] spad_rdata = 16'h0000;
    assign bus.mem_rdata = spad_rdata;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) spad[bus.mem_addr] <= bus.mem_wdata;
            else            spad_rdata <= spad[bus.mem_addr];
        end
    end

    // ---------------- counters and check helper --------------------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------------------------
    logic [15:0] m_mem [DEPTH] = '{default: 16'h0000};
    int          m_last;     // last winner: 0 wr, 1 acc, 2 rd
    bit          m_wb;       // accumulate write-back due this cycle
    int          m_wb_addr;
    logic [15:0] m_wb_add;
    int          m_clr;      // address being zeroed this cycle, -1 if none
    bit          m_pend, m_ovf, m_rdv, m_done;
    logic [15:0] m_rd;       // value expected on rd_data

    // observations from the most recent cycle (sampled at the falling edge)
    logic [31:0] obs_gnt, obs_busy, obs_en, obs_we, obs_addr, obs_wdata;
    logic [31:0] obs_rdv, obs_rdata, obs_ovf, obs_done;

    task automatic model_reset();
        m_last = 2; m_wb = 0; m_clr = -1;
        m_pend = 0; m_ovf = 0; m_rdv = 0; m_done = 0; m_rd = 16'h0;
    endtask

    // 0 wr, 1 acc, 2 rd, 3 none, 7 more than one
    function automatic logic [31:0] gcode();
        int n;
        n = int'(bus.wr_gnt) + int'(bus.acc_gnt) + int'(bus.rd_gnt);
        if (n > 1)        return 32'd7;
        if (bus.wr_gnt)   return 32'd0;
        if (bus.acc_gnt)  return 32'd1;
        if (bus.rd_gnt)   return 32'd2;
        return 32'd3;
    endfunction

    task automatic model_cycle();
        logic [31:0] e_gnt, e_en, e_we, e_addr, e_wd;
        logic [2:0]  r;
        logic [15:0] a, s;
        obs_gnt   = gcode();
        obs_busy  = 32'(bus.busy);
        obs_en    = 32'(bus.mem_en);
        obs_we    = 32'(bus.mem_we);
        obs_addr  = 32'(bus.mem_addr);
        obs_wdata = 32'(bus.mem_wdata);
        obs_rdv   = 32'(bus.rd_valid);
        obs_rdata = 32'(bus.rd_data);
        obs_ovf   = 32'(bus.acc_ovf);
        obs_done  = 32'(bus.clear_done);

        if (rst) begin
            chk("rst_gnt",   obs_gnt,   32'd3);
            chk("rst_busy",  obs_busy,  32'd0);
            chk("rst_en",    obs_en,    32'd0);
            chk("rst_we",    obs_we,    32'd0);
            chk("rst_addr",  obs_addr,  32'd0);
            chk("rst_wdata", obs_wdata, 32'd0);
            chk("rst_rdv",   obs_rdv,   32'd0);
            chk("rst_rdata", obs_rdata, 32'd0);
            chk("rst_ovf",   obs_ovf,   32'd0);
            chk("rst_done",  obs_done,  32'd0);
            model_reset();
            return;
        end

        r = {bus.rd_req, bus.acc_req, bus.wr_req};
        e_gnt = 32'd3; e_en = 0; e_we = 0; e_addr = 0; e_wd = 0;
        if (m_clr >= 0) begin
            e_en = 1; e_we = 1; e_addr = 32'(m_clr);
        end else if (m_wb) begin
            s = m_mem[m_wb_addr] + m_wb_add;
            e_en = 1; e_we = 1; e_addr = 32'(m_wb_addr); e_wd = 32'(s);
        end else if (!(m_pend || bus.clear)) begin
            for (int k = 1; k <= 3; k++) begin
                int sidx;
                sidx = (m_last + k) % 3;
                if (e_gnt == 32'd3 && r[sidx]) e_gnt = 32'(sidx);
            end
            case (e_gnt)
                32'd0: begin e_en = 1; e_we = 1; e_addr = 32'(bus.wr_addr); e_wd = 32'(bus.wr_data); end
                32'd1: begin e_en = 1; e_addr = 32'(bus.acc_addr); end
                32'd2: begin e_en = 1; e_addr = 32'(bus.rd_addr); end
                default: ;
            endcase
        end

        chk("gnt",   obs_gnt,  e_gnt);
        chk("busy",  obs_busy, 32'((m_clr >= 0) || m_wb));
        chk("mem_en", obs_en,  e_en);
        chk("mem_we", obs_we,  e_we);
        if (e_en != 0) chk("mem_addr", obs_addr, e_addr);
        if (e_en != 0 && e_we != 0) chk("mem_wdata", obs_wdata, e_wd);
        chk("rd_valid", obs_rdv,   32'(m_rdv));
        chk("rd_data",  obs_rdata, 32'(m_rd));
        chk("acc_ovf",  obs_ovf,   32'(m_ovf));
        chk("clr_done", obs_done,  32'(m_done));

        // advance to the next cycle
        m_rdv = 0; m_done = 0;
        if (m_clr >= 0) begin
            m_mem[m_clr] = 16'h0;
            if (m_clr == DEPTH - 1) begin m_clr = -1; m_done = 1; end
            else m_clr++;
        end else if (m_wb) begin
            a = m_mem[m_wb_addr];
            s = a + m_wb_add;
            if (a[15] == m_wb_add[15] && s[15] != a[15]) m_ovf = 1;
            m_mem[m_wb_addr] = s;
            m_wb = 0;
            if (bus.clear) m_pend = 1;
        end else if (m_pend || bus.clear) begin
            m_clr = 0; m_pend = 0; m_ovf = 0;
        end else if (e_gnt != 32'd3) begin
            m_last = int'(e_gnt);
            case (e_gnt)
                32'd0: m_mem[bus.wr_addr] = bus.wr_data;
                32'd1: begin m_wb = 1; m_wb_addr = int'(bus.acc_addr); m_wb_add = bus.acc_data; end
                default: begin m_rdv = 1; m_rd = m_mem[bus.rd_addr]; end
            endcase
        end
    endtask

    // one clock: model check at the falling edge, return just after the rise
    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.clear = 0; bus.wr_req = 0; bus.acc_req = 0; bus.rd_req = 0;
    endtask

    // pulse clear and measure the sweep
    task automatic run_clear(output int busy_n, output logic [31:0] first_addr,
                             output logic [31:0] done_seen);
        busy_n = 0; first_addr = 32'hDEAD; done_seen = 0;
        bus.clear = 1;
        step();
        bus.clear = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (obs_busy != 0) begin
                if (busy_n == 0) first_addr = obs_addr;
                busy_n++;
            end else begin
                done_seen = obs_done;
                break;
            end
        end
    endtask

    int          seq [8];
    int          exp_seq [8] = '{0, 1, 3, 2, 0, 1, 3, 2};
    int          bn;
    logic [31:0] fa, ds;

    initial begin
        rst = 1;
        bus.clear = 0; bus.wr_req = 1; bus.acc_req = 0; bus.rd_req = 0;
        bus.wr_addr = 0; bus.wr_data = 0; bus.acc_addr = 0; bus.acc_data = 0; bus.rd_addr = 0;
        model_reset();
        step(); step();      // reset state, with a request held to show no grant leaks
        idle();
        rst = 0;

        // single write then read
        bus.wr_req = 1; bus.wr_addr = 4'd3; bus.wr_data = 16'h0012;
        step();
        chk("t1_wr_gnt", obs_gnt, 32'd0);
        bus.wr_req = 0; bus.rd_req = 1; bus.rd_addr = 4'd3;
        step();
        chk("t1_rd_gnt", obs_gnt, 32'd2);
        bus.rd_req = 0;
        step();
        chk("t1_rd_valid", obs_rdv, 32'd1);
        chk("t1_rd_data", obs_rdata, 32'h0012);
        $display("txn: single write/read, rd_data=0x%0h", obs_rdata);

        // round-robin with all three held from reset
        rst = 1;
        step();
        bus.wr_req = 1;  bus.wr_addr = 4'd1;  bus.wr_data = 16'h0100;
        bus.acc_req = 1; bus.acc_addr = 4'd2; bus.acc_data = 16'h0001;
        bus.rd_req = 1;  bus.rd_addr = 4'd1;
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            seq[i] = int'(obs_gnt);
        end
        for (int i = 0; i < 8; i++) chk($sformatf("rr_seq%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
        $display("txn: round-robin %0d %0d %0d %0d %0d %0d %0d %0d",
                 seq[0], seq[1], seq[2], seq[3], seq[4], seq[5], seq[6], seq[7]);
        idle();

        // accumulate wrap and sticky overflow
        bus.wr_req = 1; bus.wr_addr = 4'd5; bus.wr_data = 16'h7FFF;
        step();
        idle();
        bus.acc_req = 1; bus.acc_addr = 4'd5; bus.acc_data = 16'h0001;
        step();
        chk("ovf_acc_gnt", obs_gnt, 32'd1);
        idle();
        step();
        chk("ovf_wb_addr", obs_addr, 32'd5);
        chk("ovf_wb_data", obs_wdata, 32'h8000);
        step();
        chk("ovf_set", obs_ovf, 32'd1);
        bus.acc_req = 1;
        step();
        idle();
        step();
        chk("ovf_wb2_data", obs_wdata, 32'h8001);
        step();
        chk("ovf_sticky", obs_ovf, 32'd1);
        $display("txn: accumulate 0x7fff+1 -> ovf=%0d", obs_ovf);

        // fill all entries, then clear
        for (int i = 0; i < DEPTH; i++) begin
            bus.wr_req = 1; bus.wr_addr = 4'(i); bus.wr_data = 16'(i * 16'h0111 + 1);
            step();
        end
        idle();
        run_clear(bn, fa, ds);
        chk("clr_busy_cycles", 32'(bn), 32'd16);
        chk("clr_first_addr", fa, 32'd0);
        chk("clr_done_pulse", ds, 32'd1);
        chk("clr_ovf_cleared", obs_ovf, 32'd0);
        bus.rd_req = 1; bus.rd_addr = 4'd9;
        step();
        idle();
        step();
        chk("clr_read_zero", obs_rdata, 32'd0);
        $display("txn: clear busy=%0d cycles, entry9=0x%0h", bn, obs_rdata);

        // clear arriving during the accumulate write-back
        bus.acc_req = 1; bus.acc_addr = 4'd4; bus.acc_data = 16'h0003;
        step();
        bus.acc_req = 0; bus.clear = 1;
        step();
        chk("rmw_wb_we", obs_we, 32'd1);
        chk("rmw_wb_addr", obs_addr, 32'd4);
        bus.clear = 0;
        bus.wr_req = 1; bus.wr_addr = 4'd2; bus.wr_data = 16'h0055;
        step();
        chk("rmw_no_gnt", obs_gnt, 32'd3);
        step();
        chk("rmw_clr_busy", obs_busy, 32'd1);
        chk("rmw_clr_addr0", obs_addr, 32'd0);
        bn = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            bn++;
            if (obs_gnt == 32'd0) break;
        end
        chk("rmw_wr_wait", 32'(bn), 32'd16);
        idle();
        $display("txn: clear during RMW, wr granted %0d cycles after sweep start", bn);

        // reset in the middle of a clear
        bus.clear = 1;
        step();
        bus.clear = 0;
        for (int i = 0; i < 7; i++) step();
        chk("mid_clr_addr6", obs_addr, 32'd6);
        bus.wr_req = 1;
        rst = 1;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_en", 32'(bus.mem_en), 32'd0);
        chk("mid_rst_we", 32'(bus.mem_we), 32'd0);
        chk("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("mid_rst_gnt", gcode(), 32'd3);
        chk("mid_rst_done", 32'(bus.clear_done), 32'd0);
        model_reset();
        idle();
        #1;
        rst = 0;
        run_clear(bn, fa, ds);
        chk("re_clr_busy_cycles", 32'(bn), 32'd16);
        chk("re_clr_first_addr", fa, 32'd0);
        chk("re_clr_done", ds, 32'd1);
        $display("txn: reset mid-clear, new sweep %0d cycles from addr %0d", bn, fa);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if (!bus.wr_req || obs_gnt == 32'd0) begin
                bus.wr_req  = ($urandom_range(0, 99) < 45);
                bus.wr_addr = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, DEPTH - 1));
                bus.wr_data = 16'($urandom);
            end
            if (!bus.acc_req || obs_gnt == 32'd1) begin
                bus.acc_req  = ($urandom_range(0, 99) < 45);
                bus.acc_addr = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, DEPTH - 1));
                bus.acc_data = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 15));
            end
            if (!bus.rd_req || obs_gnt == 32'd2) begin
                bus.rd_req  = ($urandom_range(0, 99) < 45);
                bus.rd_addr = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, DEPTH - 1));
            end
            bus.clear = ($urandom_range(0, 149) == 0);
            step();
            if (obs_rdv != 0) $display("txn: rand cycle %0d rd_data=0x%0h", c, obs_rdata);
        end
        idle();
        step(); step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
